stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl_if.sv | 32 +++
 rtl/stack_ctrl.sv | 130 +++++++++++++
 tb/tb_stack_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_if.sv
// Command/stack/result signal bundle for stack_ctrl.
// The slave modport is the controller; the master modport is whoever drives commands and models the stack.
interface stack_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              stk_push;
  logic              stk_pop;
  logic [DATA_W-1:0] stk_data;
  logic [DATA_W-1:0] stk_top;
  logic [DATA_W-1:0] stk_top_m1;
  logic              stk_full;
  logic              stk_empty;
  logic [5:0]        stk_ptr;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              error;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, stk_top, stk_top_m1, stk_full, stk_empty, stk_ptr,
    output cmd_ready, stk_push, stk_pop, stk_data, result, result_valid, error, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, stk_top, stk_top_m1, stk_full, stk_empty, stk_ptr,
    input  cmd_ready, stk_push, stk_pop, stk_data, result, result_valid, error, busy
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack-machine command sequencer: turns one accepted command into pop/push strobes
// on an external stack and reports a registered result with an error flag.
module stack_ctrl #(
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         rst,
  stack_ctrl_if.slave bus
);

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_DUP  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [2:0] {IDLE, POP_A, POP_B, PUSH, CLR, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              accept;
  logic              fault;
  logic [DATA_W-1:0] res_val;

  // Modulo-2^W arithmetic: carry and borrow simply fall off the top.
  function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return '0;
    endcase
  endfunction

  assign accept = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    fault = 1'b0;
    case (bus.cmd_op)
      OP_PUSH:                        fault = bus.stk_full;
      OP_POP:                         fault = bus.stk_empty;
      OP_DUP:                         fault = bus.stk_full || bus.stk_empty;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  fault = (bus.stk_ptr < 6'd2);
      default:                        fault = 1'b0;
    endcase
  end

  // Operand capture at accept; A is the entry below the top, B is the top.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= bus.cmd_op;
      data_q <= bus.cmd_data;
      a_q    <= bus.stk_top_m1;
      b_q    <= bus.stk_top;
    end
  end

  always_comb begin
    case (op_q)
      OP_PUSH:        res_val = data_q;
      OP_POP, OP_DUP: res_val = b_q;
      OP_CLR:         res_val = '0;
      default:        res_val = alu(op_q, a_q, b_q);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fault) next_state = DONE;
          else begin
            case (bus.cmd_op)
              OP_PUSH, OP_DUP: next_state = PUSH;
              OP_CLR:          next_state = CLR;
              default:         next_state = POP_A;
            endcase
          end
        end
      end
      POP_A:   next_state = (op_q == OP_POP) ? DONE : POP_B;
      POP_B:   next_state = PUSH;
      PUSH:    next_state = DONE;
      CLR:     next_state = bus.stk_empty ? DONE : CLR;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Gating cmd_ready with rst keeps it low for the whole reset window even though state sits in IDLE.
  always_comb begin
    bus.cmd_ready    = (state == IDLE) && !rst;
    bus.busy         = (state != IDLE);
    bus.result_valid = (state == DONE);
    bus.stk_push     = (state == PUSH);
    bus.stk_pop      = (state == POP_A) || (state == POP_B) || ((state == CLR) && !bus.stk_empty);
    bus.stk_data     = (state == PUSH) ? res_val : '0;
  end

  // Result and error are loaded on the edge entering DONE and held until the next DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.result <= '0;
      bus.error  <= 1'b0;
    end else if (accept && fault) begin
      bus.result <= '0;
      bus.error  <= 1'b1;
    end else if ((state != IDLE) && (state != DONE) && (next_state == DONE)) begin
      bus.result <= res_val;
      bus.error  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: a queue-based stack answers the strobes and a
// command-level reference model predicts result, error, latency and strobe counts.
module tb_stack_ctrl;

  localparam int DEPTH = 16;
  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_DUP  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
    logic [7:0]  lat;
    logic [7:0]  pushes;
    logic [7:0]  pops;
  } outcome_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_ctrl_if #(.DATA_W(32)) bus ();
  stack_ctrl #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] q[$];
  logic [31:0] mq[$];
  logic        force_full = 1'b0;
  logic        full_q = 1'b0;
  logic        stk_clear = 1'b0;
  int          push_cnt = 0;
  int          pop_cnt = 0;
  int          bad_strobe = 0;
  int          checks = 0;
  int          errors = 0;

  assign bus.stk_full = full_q | force_full;

  // Stack model: reacts to the DUT strobes, republishes top/occupancy after each edge.
  always @(posedge clk) begin
    if (stk_clear) q.delete();
    else begin
      if (bus.stk_push && bus.stk_pop) bad_strobe <= bad_strobe + 1;
      if (bus.stk_push) begin
        q.push_back(bus.stk_data);
        push_cnt <= push_cnt + 1;
      end
      if (bus.stk_pop) begin
        if (q.size() > 0) void'(q.pop_back());
        pop_cnt <= pop_cnt + 1;
      end
    end
    if (!bus.stk_push && bus.stk_data !== 32'h0) bad_strobe <= bad_strobe + 1;
    bus.stk_top    <= (q.size() > 0) ? q[q.size()-1] : 32'h0;
    bus.stk_top_m1 <= (q.size() > 1) ? q[q.size()-2] : 32'h0;
    bus.stk_empty  <= (q.size() == 0);
    bus.stk_ptr    <= 6'(q.size());
    full_q         <= (q.size() >= DEPTH);
  end

  function automatic string show(input outcome_t o);
    return $sformatf("res=%h err=%0d lat=%0d push=%0d pop=%0d", o.res, o.err, o.lat, o.pushes, o.pops);
  endfunction

  // Reference model: command semantics applied to the model stack mq.
  function automatic outcome_t predict(input logic [2:0] op, input logic [31:0] d);
    outcome_t    o;
    int          n;
    logic        full;
    logic        bad;
    logic [31:0] a;
    logic [31:0] b;
    o    = '0;
    n    = mq.size();
    full = force_full || (n >= DEPTH);
    bad  = 1'b0;
    b    = (n > 0) ? mq[n-1] : 32'h0;
    a    = (n > 1) ? mq[n-2] : 32'h0;
    case (op)
      OP_PUSH: if (full) bad = 1'b1;
               else begin o.res = d; o.lat = 2; o.pushes = 1; mq.push_back(d); end
      OP_POP:  if (n == 0) bad = 1'b1;
               else begin o.res = b; o.lat = 2; o.pops = 1; void'(mq.pop_back()); end
      OP_DUP:  if (full || n == 0) bad = 1'b1;
               else begin o.res = b; o.lat = 2; o.pushes = 1; mq.push_back(b); end
      OP_CLR:  begin o.lat = 8'(n + 2); o.pops = 8'(n); mq.delete(); end
      default: if (n < 2) bad = 1'b1;
               else begin
                 case (op)
                   OP_ADD:  o.res = a + b;
                   OP_SUB:  o.res = a - b;
                   OP_AND:  o.res = a & b;
                   default: o.res = a | b;
                 endcase
                 o.lat = 4; o.pops = 2; o.pushes = 1;
                 void'(mq.pop_back()); void'(mq.pop_back()); mq.push_back(o.res);
               end
    endcase
    if (bad) begin o.err = 1'b1; o.lat = 1; end
    return o;
  endfunction

  // Offers one command, waits for its completion pulse, reports what was observed.
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] d, output outcome_t obs);
    int p0, q0, cyc, w;
    obs = '0;
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_data = d; bus.cmd_valid = 1'b1;
    w = 0;
    while (!bus.cmd_ready && w < 20) begin @(negedge clk); w++; end
    p0 = push_cnt; q0 = pop_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_data = $urandom; bus.cmd_op = 3'($urandom);
    cyc = 1;
    while (!bus.result_valid && cyc < 40) begin @(negedge clk); cyc++; end
    obs.res    = bus.result;
    obs.err    = bus.error;
    obs.lat    = bus.result_valid ? 8'(cyc) : 8'hFF;
    obs.pushes = 8'(push_cnt - p0);
    obs.pops   = 8'(pop_cnt - q0);
  endtask

  task automatic flush();
    @(negedge clk); stk_clear = 1'b1;
    @(posedge clk); #1 stk_clear = 1'b0;
    mq.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'b0; bus.cmd_data = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.stk_push, bus.stk_pop, bus.result_valid, bus.error} !== 6'b0 ||
        bus.stk_data !== 32'h0 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b busy=%b push=%b pop=%b rv=%b err=%b data=%h res=%h, want all 0",
               bus.cmd_ready, bus.busy, bus.stk_push, bus.stk_pop, bus.result_valid, bus.error, bus.stk_data, bus.result);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b, want ready=1 busy=0", bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_sub();
    logic [2:0]  ops[3] = '{OP_PUSH, OP_PUSH, OP_SUB};
    logic [31:0] ds[3]  = '{32'd5, 32'd3, 32'd0};
    outcome_t    exp, obs;
    flush();
    for (int i = 0; i < 3; i++) begin
      exp = predict(ops[i], ds[i]);
      run_cmd(ops[i], ds[i], obs);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL sub[%0d]: got %s, want %s", i, show(obs), show(exp)); end
    end
    checks++;
    if (obs.res !== 32'h2 || obs.lat !== 8'd4 || obs.pops !== 8'd2 || q.size() != 1 || q[0] !== 32'h2) begin
      errors++;
      $display("FAIL sub_value: got res=%h lat=%0d pops=%0d depth=%0d, want res=00000002 lat=4 pops=2 depth=1",
               obs.res, obs.lat, obs.pops, q.size());
    end
  endtask

  task automatic test_pop_empty();
    outcome_t exp, obs;
    flush();
    exp = predict(OP_POP, 32'h0);
    run_cmd(OP_POP, 32'h0, obs);
    checks++;
    if (obs !== exp || obs.err !== 1'b1 || obs.lat !== 8'd1 || obs.res !== 32'h0) begin
      errors++; $display("FAIL pop_empty: got %s, want %s", show(obs), show(exp));
    end
  endtask

  task automatic test_add_wrap();
    logic [2:0]  ops[3] = '{OP_PUSH, OP_PUSH, OP_ADD};
    logic [31:0] ds[3]  = '{32'hFFFF_FFFF, 32'h1, 32'h0};
    outcome_t    exp, obs;
    flush();
    for (int i = 0; i < 3; i++) begin
      exp = predict(ops[i], ds[i]);
      run_cmd(ops[i], ds[i], obs);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL add_wrap[%0d]: got %s, want %s", i, show(obs), show(exp)); end
    end
    checks++;
    if (obs.res !== 32'h0 || obs.err !== 1'b0 || q.size() != 1 || q[0] !== 32'h0) begin
      errors++; $display("FAIL add_wrap_value: got res=%h err=%b depth=%0d, want res=00000000 err=0 depth=1",
                         obs.res, obs.err, q.size());
    end
  endtask

  task automatic test_full_dup();
    logic [2:0]  ops[3] = '{OP_PUSH, OP_DUP, OP_POP};
    logic [31:0] ds[3]  = '{32'hCAFE_F00D, 32'h0, 32'h0};
    outcome_t    exp, obs;
    flush();
    for (int i = 0; i < 3; i++) begin
      force_full = (i > 0);
      exp = predict(ops[i], ds[i]);
      run_cmd(ops[i], ds[i], obs);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL full_dup[%0d]: got %s, want %s", i, show(obs), show(exp)); end
      if (i == 1) begin
        checks++;
        if (obs.err !== 1'b1 || obs.pushes !== 8'd0) begin
          errors++; $display("FAIL full_dup_fault: got err=%b pushes=%0d, want err=1 pushes=0", obs.err, obs.pushes);
        end
      end
    end
    force_full = 1'b0;
    checks++;
    if (obs.res !== 32'hCAFE_F00D || obs.err !== 1'b0) begin
      errors++; $display("FAIL full_dup_pop: got res=%h err=%b, want res=cafef00d err=0", obs.res, obs.err);
    end
  endtask

  task automatic test_clr();
    outcome_t exp, obs;
    logic [31:0] d;
    flush();
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      exp = predict(OP_PUSH, d);
      run_cmd(OP_PUSH, d, obs);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL clr_fill[%0d]: got %s, want %s", i, show(obs), show(exp)); end
    end
    exp = predict(OP_CLR, 32'h0);
    run_cmd(OP_CLR, 32'h0, obs);
    checks++;
    if (obs !== exp || obs.pops !== 8'd3 || obs.lat !== 8'd5 || obs.res !== 32'h0 || q.size() != 0) begin
      errors++; $display("FAIL clr: got %s depth=%0d, want %s depth=0", show(obs), q.size(), show(exp));
    end
    exp = predict(OP_CLR, 32'h0);
    run_cmd(OP_CLR, 32'h0, obs);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL clr_empty: got %s, want %s", show(obs), show(exp)); end
  endtask

  task automatic test_hold();
    outcome_t    exp, obs;
    logic [31:0] r;
    logic        e;
    flush();
    exp = predict(OP_PUSH, 32'h1234_5678);
    run_cmd(OP_PUSH, 32'h1234_5678, obs);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL hold_cmd: got %s, want %s", show(obs), show(exp)); end
    r = 32'h1234_5678; e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.result !== r || bus.error !== e || bus.result_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        errors++; $display("FAIL hold[%0d]: got res=%h err=%b rv=%b ready=%b, want res=%h err=%b rv=0 ready=1",
                           i, bus.result, bus.error, bus.result_valid, bus.cmd_ready, r, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    outcome_t exp, obs;
    logic     rv;
    flush();
    for (int i = 0; i < 2; i++) begin
      exp = predict(OP_PUSH, 32'(10 * (i + 1)));
      run_cmd(OP_PUSH, 32'(10 * (i + 1)), obs);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL rmid_fill[%0d]: got %s, want %s", i, show(obs), show(exp)); end
    end
    @(negedge clk); bus.cmd_op = OP_ADD; bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.cmd_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.stk_pop !== 1'b1) begin
      errors++; $display("FAIL rmid_pop_a: got busy=%b ready=%b pop=%b, want busy=1 ready=0 pop=1",
                         bus.busy, bus.cmd_ready, bus.stk_pop);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.stk_push, bus.stk_pop, bus.result_valid, bus.error} !== 6'b0 ||
        bus.stk_data !== 32'h0 || bus.result !== 32'h0) begin
      errors++; $display("FAIL rmid_abort: got ready=%b busy=%b push=%b pop=%b rv=%b err=%b res=%h, want all 0",
                         bus.cmd_ready, bus.busy, bus.stk_push, bus.stk_pop, bus.result_valid, bus.error, bus.result);
    end
    void'(mq.pop_back());
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got ready=%b, want 1", bus.cmd_ready); end
    rv = bus.result_valid;
    repeat (5) begin @(negedge clk); rv = rv | bus.result_valid; end
    checks++;
    if (rv !== 1'b0 || q.size() != mq.size() || q[0] !== mq[0]) begin
      errors++; $display("FAIL rmid_after: got rv=%b depth=%0d, want rv=0 depth=%0d", rv, q.size(), mq.size());
    end
  endtask

  task automatic test_random();
    outcome_t    exp, obs;
    logic [2:0]  op;
    logic [31:0] d;
    int          r;
    flush();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: op = OP_PUSH;
        4:          op = OP_POP;
        5:          op = OP_ADD;
        6:          op = OP_SUB;
        7:          op = ($urandom_range(0, 1) == 0) ? OP_AND : OP_OR;
        8:          op = OP_DUP;
        default:    op = ($urandom_range(0, 3) == 0) ? OP_CLR : OP_PUSH;
      endcase
      d = $urandom;
      exp = predict(op, d);
      run_cmd(op, d, obs);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL rand[%0d] op=%0d: got %s, want %s", i, op, show(obs), show(exp)); end
      checks++;
      if (q.size() != mq.size() || (q.size() > 0 && q[q.size()-1] !== mq[mq.size()-1])) begin
        errors++; $display("FAIL rand_stack[%0d]: got depth=%0d, want depth=%0d", i, q.size(), mq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_pop_empty();
    test_add_wrap();
    test_full_dup();
    test_clr();
    test_hold();
    test_reset_mid();
    test_random();
    checks++;
    if (bad_strobe !== 0) begin
      errors++; $display("FAIL strobe_rules: got %0d violations, want 0", bad_strobe);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
